// File: rtl/bool2_unit.sv
// bool2_unit: registered two-input Boolean function unit, W bits wide.
// Each result bit is r[i] = fn[{x[i], y[i]}]. The truth table fn is sampled
// with the operands, so r depends only on what was accepted.
//
// Optional feature macro: BOOL2_SWEEP_EN builds a truth-table self-test
// sweep that drives all four (x, y) combinations through the same slices.
// When it is not defined, the sweep outputs are tied to 0.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   fn[3:0]                 truth table, index = 2*x + y
//   in_valid / in_ready     operand handshake (x, y, fn)
//   x, y [W-1:0]            operands
//   out_valid / out_ready   result handshake
//   r [W-1:0]               registered result
//   sweep_start             request a sweep (ignored unless idle and empty)
//   sweep_busy, sweep_done  sweep running / one-cycle completion pulse
//   sweep_tt[3:0], sweep_ok captured truth table / all slices agreed

module bool2_slice (
    input  logic [3:0] fn,
    input  logic       a,
    input  logic       b,
    output logic       q
);
    assign q = fn[{a, b}];
endmodule

module bool2_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   fn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    input  logic         sweep_start,
    output logic         sweep_busy,
    output logic         sweep_done,
    output logic [3:0]   sweep_tt,
    output logic         sweep_ok
);
    logic [3:0]   slice_fn;
    logic [W-1:0] slice_x, slice_y, slice_q;
    logic         accept;
    logic         out_free;

    // One output register: free when empty or being drained this cycle.
    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_slice
            bool2_slice u_slice (
                .fn (slice_fn),
                .a  (slice_x[i]),
                .b  (slice_y[i]),
                .q  (slice_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r         <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            r         <= slice_q;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BOOL2_SWEEP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] idx;
    logic [3:0] sweep_fn;
    logic       start_ok;

    // A sweep may only start with an empty output and no competing accept.
    assign start_ok = sweep_start && (state == S_IDLE) && !out_valid && !accept;

    assign in_ready   = out_free && (state == S_IDLE);
    assign sweep_busy = (state == S_RUN);
    assign sweep_done = (state == S_DONE);

    // During RUN the slices see the broadcast combination and the latched fn;
    // accepts are blocked then, so r cannot pick up sweep results.
    assign slice_fn = (state == S_RUN) ? sweep_fn : fn;
    assign slice_x  = (state == S_RUN) ? {W{idx[1]}} : x;
    assign slice_y  = (state == S_RUN) ? {W{idx[0]}} : y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_ok) state_nxt = S_RUN;
            S_RUN:  if (idx == 2'd3) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            sweep_fn <= '0;
            sweep_tt <= '0;
            sweep_ok <= 1'b0;
        end else if (start_ok) begin
            idx      <= '0;
            sweep_fn <= fn;
            sweep_tt <= '0;
            sweep_ok <= 1'b1;
        end else if (state == S_RUN) begin
            idx           <= idx + 2'd1;
            sweep_tt[idx] <= slice_q[0];
            if (slice_q != {W{slice_q[0]}}) sweep_ok <= 1'b0;
        end
    end
`else
    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign in_ready   = out_free;
    assign slice_fn   = fn;
    assign slice_x    = x;
    assign slice_y    = y;
    assign sweep_busy = 1'b0;
    assign sweep_done = 1'b0;
    assign sweep_tt   = 4'h0;
    assign sweep_ok   = 1'b0;
`endif

endmodule
